// File: rtl/jk_latch.sv
//==============================================================================
// Module   : jk_latch
// Brief    : Level-sensitive JK latch. Transparent while clk=1, holding while
//            clk=0. The j=k=1 toggle fires at most once per transparent phase
//            and is re-armed only when clk returns low. Asynchronous
//            active-low reset forces q=0 and spends the current phase's toggle.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module jk_latch (
    input  logic clk,   // latch enable: transparent high, opaque low
    input  logic rst,   // asynchronous, active-low
    input  logic j,     // set request
    input  logic k,     // clear request
    output logic q,     // stored state
    output logic qbar   // complement of q
);

    // Stored bit of the latch.
    logic q_state;

    // High once the current transparent phase has used its single toggle.
    // Reset also sets it, so a j=k=1 present at reset release cannot toggle
    // until the next high phase. Clearing it while clk=0 re-arms the toggle.
    logic toggle_spent;

    // Transparent update while clk=1; reset dominates; opaque phase re-arms the toggle.
    always_latch begin
        if (!rst) begin
            q_state      <= 1'b0;
            toggle_spent <= 1'b1;
        end else if (clk) begin
            case ({j, k})
                2'b01: q_state <= 1'b0;
                2'b10: q_state <= 1'b1;
                2'b11: begin
                    // Toggle exactly once per phase; once spent, 11 behaves as hold
                    // so the latch cannot ring while j=k=1 stays asserted.
                    if (!toggle_spent) begin
                        q_state      <= ~q_state;
                        toggle_spent <= 1'b1;
                    end
                end
                default: ; // 00 holds
            endcase
        end else begin
            toggle_spent <= 1'b0;
        end
    end

    // Both outputs come from the single stored bit, so they can never disagree.
    assign q    = q_state;
    assign qbar = ~q_state;

endmodule

`default_nettype wire

// File: tb/tb_jk_latch.sv
//==============================================================================
// Module   : tb_jk_latch
// Brief    : Directed bench for jk_latch, plus a master-slave pair built from
//            two instances and compared against a JK flip-flop model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_jk_latch;

    logic clk;
    logic clk_n;
    logic rst;
    logic j;
    logic k;
    logic q;
    logic qbar;

    // master-slave pair
    logic mj;
    logic mk;
    logic qm;
    logic qm_bar;
    logic qs;
    logic qs_bar;

    int n_vec;
    int n_miss;

    assign clk_n = ~clk;

    jk_latch dut (
        .clk  (clk),
        .rst  (rst),
        .j    (j),
        .k    (k),
        .q    (q),
        .qbar (qbar)
    );

    jk_latch u_master (
        .clk  (clk),
        .rst  (rst),
        .j    (mj),
        .k    (mk),
        .q    (qm),
        .qbar (qm_bar)
    );

    jk_latch u_slave (
        .clk  (clk_n),
        .rst  (rst),
        .j    (qm),
        .k    (qm_bar),
        .q    (qs),
        .qbar (qs_bar)
    );

    // Single comparison point: counts every check, reports any miscompare.
    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Checks q and its complement on the directed DUT.
    task automatic check_q(input string tag, input logic exp);
        check_bit({tag, ".q"},    q,    exp);
        check_bit({tag, ".qbar"}, qbar, ~exp);
    endtask

    task automatic set_jk(input logic jv, input logic kv);
        j = jv;
        k = kv;
        #1;
    endtask

    logic       ms_exp;
    logic [1:0] vec;

    initial begin
        n_vec  = 0;
        n_miss = 0;
        clk = 1'b0; rst = 1'b1; j = 1'b0; k = 1'b0; mj = 1'b0; mk = 1'b0;
        #1;

        // Reset asserted: q=0 regardless of clk and j=k=1
        rst = 1'b0;
        #1 check_q("rst_assert", 1'b0);
        set_jk(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            clk = 1'b1; #2 check_q("rst_clk_hi", 1'b0);
            clk = 1'b0; #2 check_q("rst_clk_lo", 1'b0);
        end

        // Release with clk low: stays 0 until clk goes high
        set_jk(1'b1, 1'b0);
        rst = 1'b1;
        #2 check_q("rel_clk_lo", 1'b0);

        // Set, then clear in the same phase, then opaque ignores j
        clk = 1'b1; #1 check_q("set", 1'b1);
        set_jk(1'b0, 1'b1); check_q("clear_same_phase", 1'b0);
        clk = 1'b0; #1;
        set_jk(1'b1, 1'b0); check_q("opaque_set_ignored", 1'b0);

        // Toggle once per phase, held j=k=1 does not ring
        set_jk(1'b1, 1'b1); check_q("opaque_11", 1'b0);
        clk = 1'b1; #1 check_q("toggle_up", 1'b1);
        #4 check_q("toggle_hold_phase", 1'b1);
        clk = 1'b0; #2 check_q("toggle_opaque", 1'b1);
        clk = 1'b1; #1 check_q("toggle_down", 1'b0);
        clk = 1'b0; #2;

        // After the single toggle, 01/10 still act; a return to 11 holds
        clk = 1'b1; #1 check_q("t2_toggle", 1'b1);
        set_jk(1'b0, 1'b1); check_q("t2_clear", 1'b0);
        set_jk(1'b1, 1'b1); check_q("t2_11_hold0", 1'b0);
        set_jk(1'b1, 1'b0); check_q("t2_set", 1'b1);
        set_jk(1'b1, 1'b1); check_q("t2_11_hold1", 1'b1);
        clk = 1'b0; #1;

        // Opaque phase: all four j/k combinations hold q=1
        set_jk(1'b0, 1'b0); check_q("op_00", 1'b1);
        set_jk(1'b0, 1'b1); check_q("op_01", 1'b1);
        set_jk(1'b1, 1'b0); check_q("op_10", 1'b1);
        set_jk(1'b1, 1'b1); check_q("op_11", 1'b1);
        set_jk(1'b0, 1'b0);
        clk = 1'b1; #1 check_q("tr_00_hold", 1'b1);

        // Reset mid-high-phase with q=1 clears at once
        rst = 1'b0; #1 check_q("rst_mid_phase", 1'b0);

        // Release in high phase with j=k=1: no toggle this phase
        set_jk(1'b1, 1'b1);
        rst = 1'b1; #1 check_q("rel_hi_11", 1'b0);
        #3 check_q("rel_hi_11_later", 1'b0);
        clk = 1'b0; #2;
        clk = 1'b1; #1 check_q("rel_next_phase", 1'b1);
        clk = 1'b0; #2;

        // Release in high phase with 10: transparent immediately
        clk = 1'b1; set_jk(1'b0, 1'b1); check_q("pre_rel_clear", 1'b0);
        rst = 1'b0; #1;
        set_jk(1'b1, 1'b0); check_q("held_in_rst", 1'b0);
        rst = 1'b1; #1 check_q("rel_hi_set", 1'b1);
        clk = 1'b0; #3;

        // Master-slave composition against a JK flip-flop model
        rst = 1'b0; #2 rst = 1'b1; #1;
        ms_exp = 1'b0;
        check_bit("ms_reset.q", qs, 1'b0);
        for (int i = 0; i < 20; i++) begin
            vec = 2'($urandom_range(0, 3));
            if (i == 0) vec = 2'b11;
            if (i == 1) vec = 2'b11;
            mj = vec[1];
            mk = vec[0];
            #3 clk = 1'b1;
            #5 clk = 1'b0;
            case ({mj, mk})
                2'b01:   ms_exp = 1'b0;
                2'b10:   ms_exp = 1'b1;
                2'b11:   ms_exp = ~ms_exp;
                default: ms_exp = ms_exp;
            endcase
            #1;
            check_bit($sformatf("ms%0d.q", i),    qs,     ms_exp);
            check_bit($sformatf("ms%0d.qbar", i), qs_bar, ~ms_exp);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
